commit_scoreboard: RTL and testbench

COMMIT_SCOREBOARD -- requirements
Module: commit_scoreboard

---
 rtl/commit_pkg.sv | 46 ++++
 rtl/commit_scoreboard_if.sv | 39 +++
 rtl/sb_fifo.sv | 51 +++++
 rtl/commit_scoreboard.sv | 111 +++++++++++
 tb/tb_commit_scoreboard.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_pkg.sv
// Shared types for the commit scoreboard: record layout, kind/error/state enums and the compare rule.
// Records carry 64-bit dest/data fields; narrower XLEN values are zero-extended on entry.
package commit_pkg;

   localparam int REC_W = 64;

   typedef enum logic [1:0] {
      KIND_NONE = 2'd0,
      KIND_REG  = 2'd1,
      KIND_MEM  = 2'd2
   } kind_e;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_DATA     = 3'd1,
      ERR_UNEXP    = 3'd2,
      ERR_TIMEOUT  = 3'd3,
      ERR_LEFTOVER = 3'd4
   } err_code_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_ERROR = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   typedef struct packed {
      kind_e              kind;
      logic [REC_W-1:0]   dest;
      logic [REC_W-1:0]   data;
   } commit_rec_t;

   // Writes to x0 are architecturally discarded, so the DUT must report zero there.
   function automatic logic rec_match(input commit_rec_t e, input commit_rec_t a);
      logic ok;
      ok = (e.kind == a.kind);
      if (ok && (e.kind != KIND_NONE)) begin
         if ((e.kind == KIND_REG) && (e.dest[4:0] == 5'd0))
            ok = (e.dest == a.dest) && (a.data == '0);
         else
            ok = (e.dest == a.dest) && (e.data == a.data);
      end
      return ok;
   endfunction

endpackage

// File: rtl/commit_scoreboard_if.sv
// Expected-record push, DUT commit stream and status outputs of the commit scoreboard.
// master = stimulus side, slave = scoreboard.
interface commit_scoreboard_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
);
   logic                    exp_valid;
   logic                    exp_ready;
   logic [1:0]              exp_kind;
   logic [XLEN-1:0]         exp_dest;
   logic [XLEN-1:0]         exp_data;
   logic                    act_valid;
   logic [1:0]              act_kind;
   logic [XLEN-1:0]         act_dest;
   logic [XLEN-1:0]         act_data;
   logic                    eot;
   logic                    mismatch;
   logic                    err;
   logic [2:0]              err_code;
   logic                    halt_req;
   logic                    done;
   logic [31:0]             match_cnt;
   logic [15:0]             mismatch_cnt;
   logic [$clog2(DEPTH):0]  occupancy;

   modport master (
      output exp_valid, exp_kind, exp_dest, exp_data,
      output act_valid, act_kind, act_dest, act_data, eot,
      input  exp_ready, mismatch, err, err_code, halt_req, done,
      input  match_cnt, mismatch_cnt, occupancy
   );

   modport slave (
      input  exp_valid, exp_kind, exp_dest, exp_data,
      input  act_valid, act_kind, act_dest, act_data, eot,
      output exp_ready, mismatch, err, err_code, halt_req, done,
      output match_cnt, mismatch_cnt, occupancy
   );
endinterface

// File: rtl/sb_fifo.sv
// Synchronous FIFO of commit records; head is visible combinationally (0-cycle read).
// Push when full and pop when empty are ignored; callers gate with o_full/o_empty.
module sb_fifo
   import commit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  commit_rec_t            i_dat,
   input  logic                   i_pop,
   output commit_rec_t            o_dat,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   commit_rec_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == CNT_FULL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dat   = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_dat;
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
endmodule

// File: rtl/commit_scoreboard.sv
// In-order checker of DUT commits against queued expected records; results registered 1 cycle after act_valid.
// Commits are never backpressured; optional idle watchdog compiled in with COMMIT_SB_TIMEOUT_EN (XLEN <= 64).
module commit_scoreboard
   import commit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 8,
   parameter int TIMEOUT     = 256,
   parameter int HALT_ON_ERR = 1
) (
   input logic                clk,
   input logic                rst,
   commit_scoreboard_if.slave sb
);
   localparam int CW = $clog2(DEPTH) + 1;

   state_e      r_state;
   logic        r_mismatch;
   logic        r_err;
   err_code_e   r_err_code;
   logic [31:0] r_match_cnt;
   logic [15:0] r_mis_cnt;

   commit_rec_t w_exp_rec, w_act_rec, w_head;
   logic        w_full, w_empty, w_run, w_push, w_pop, w_cmp_ok;
   logic        w_hit, w_miss, w_unexp, w_leftover, w_finish, w_timeout, w_any_err;
   logic [CW-1:0] w_count;
   err_code_e   w_code;

   assign w_run     = (r_state == ST_RUN);
   assign w_push    = sb.exp_valid && w_run && !w_full;
   assign w_exp_rec = '{kind: kind_e'(sb.exp_kind), dest: REC_W'(sb.exp_dest), data: REC_W'(sb.exp_data)};
   assign w_act_rec = '{kind: kind_e'(sb.act_kind), dest: REC_W'(sb.act_dest), data: REC_W'(sb.act_data)};

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_dat   (w_exp_rec),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_pop      = w_run && sb.act_valid && !w_empty;
   assign w_cmp_ok   = rec_match(w_head, w_act_rec);
   assign w_hit      = w_pop && w_cmp_ok;
   assign w_miss     = w_pop && !w_cmp_ok;
   // A same-cycle push cannot satisfy a commit: the queue is judged by its state before the edge.
   assign w_unexp    = w_run && sb.act_valid && w_empty;
   assign w_leftover = w_run && sb.eot && !w_empty;
   assign w_finish   = w_run && sb.eot && w_empty && !sb.act_valid;

`ifdef COMMIT_SB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] r_wdog;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    r_wdog <= '0;
      else if (sb.act_valid)                       r_wdog <= '0;
      else if (!w_empty && (r_wdog != WW'(TIMEOUT))) r_wdog <= r_wdog + 1'b1;
   end

   assign w_timeout = w_run && (r_wdog == WW'(TIMEOUT));
`else
   localparam bit WDOG_ON = 1'b0 && (TIMEOUT > 0);
   assign w_timeout = WDOG_ON;
`endif

   always_comb begin
      w_code = ERR_NONE;
      if (w_unexp)         w_code = ERR_UNEXP;
      else if (w_miss)     w_code = ERR_DATA;
      else if (w_timeout)  w_code = ERR_TIMEOUT;
      else if (w_leftover) w_code = ERR_LEFTOVER;
   end
   assign w_any_err = (w_code != ERR_NONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_mismatch  <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_match_cnt <= '0;
         r_mis_cnt   <= '0;
      end else begin
         r_mismatch <= w_miss;
         if (w_hit && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + 32'd1;
         if (w_miss && (r_mis_cnt != '1))  r_mis_cnt   <= r_mis_cnt + 16'd1;
         if (w_any_err) begin
            r_err <= 1'b1;
            if (r_err_code == ERR_NONE) r_err_code <= w_code;
         end
         if (w_any_err && (HALT_ON_ERR != 0)) r_state <= ST_ERROR;
         else if (w_finish)                   r_state <= ST_DONE;
      end
   end

   assign sb.exp_ready    = w_run && !w_full;
   assign sb.mismatch     = r_mismatch;
   assign sb.err          = r_err;
   assign sb.err_code     = r_err_code;
   assign sb.halt_req     = (r_state == ST_ERROR);
   assign sb.done         = (r_state == ST_DONE);
   assign sb.match_cnt    = r_match_cnt;
   assign sb.mismatch_cnt = r_mis_cnt;
   assign sb.occupancy    = w_count;
endmodule

// File: tb/tb_commit_scoreboard.sv
// Drives one stimulus stream into two scoreboards (HALT_ON_ERR=1 and =0) and checks both
// against a queue-based model every cycle, plus hand-computed literal expectations.
module tb_commit_scoreboard;
   localparam int XLEN  = 32;
   localparam int DEPTH = 8;
   localparam int TMO   = 4;
   localparam int OW    = $clog2(DEPTH) + 1;
   localparam int M_RUN = 0, M_ERR = 1, M_DONE = 2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] dest;
      logic [31:0] data;
   } mrec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        s_exp_valid, s_act_valid, s_eot;
   logic [1:0]  s_exp_kind, s_act_kind;
   logic [31:0] s_exp_dest, s_exp_data, s_act_dest, s_act_data;

   commit_scoreboard_if #(.XLEN(XLEN), .DEPTH(DEPTH)) if_h ();
   commit_scoreboard_if #(.XLEN(XLEN), .DEPTH(DEPTH)) if_c ();

   assign if_h.exp_valid = s_exp_valid;  assign if_c.exp_valid = s_exp_valid;
   assign if_h.exp_kind  = s_exp_kind;   assign if_c.exp_kind  = s_exp_kind;
   assign if_h.exp_dest  = s_exp_dest;   assign if_c.exp_dest  = s_exp_dest;
   assign if_h.exp_data  = s_exp_data;   assign if_c.exp_data  = s_exp_data;
   assign if_h.act_valid = s_act_valid;  assign if_c.act_valid = s_act_valid;
   assign if_h.act_kind  = s_act_kind;   assign if_c.act_kind  = s_act_kind;
   assign if_h.act_dest  = s_act_dest;   assign if_c.act_dest  = s_act_dest;
   assign if_h.act_data  = s_act_data;   assign if_c.act_data  = s_act_data;
   assign if_h.eot       = s_eot;        assign if_c.eot       = s_eot;

   commit_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TMO), .HALT_ON_ERR(1)) u_halt (
      .clk(clk), .rst(rst), .sb(if_h));
   commit_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TMO), .HALT_ON_ERR(0)) u_cont (
      .clk(clk), .rst(rst), .sb(if_c));

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model state, index 0 = halting scoreboard, 1 = continuing scoreboard
   mrec_t   mq [2][$];
   int      m_state [2];
   bit      m_mis [2];
   bit      m_err [2];
   int      m_code [2];
   longint  m_match [2];
   longint  m_miscnt [2];
   int      m_idle [2];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mq[d].delete();
         m_state[d] = M_RUN; m_mis[d] = 0; m_err[d] = 0; m_code[d] = 0;
         m_match[d] = 0; m_miscnt[d] = 0; m_idle[d] = 0;
      end
   endtask

   task automatic model_step(input int d);
      mrec_t h, a;
      bit    e, ok, fin;
      int    c, pre;
      m_mis[d] = 0;
      if (m_state[d] != M_RUN) return;
      pre = mq[d].size();
      e = 0; c = 0;
      a = '{kind: s_act_kind, dest: s_act_dest, data: s_act_data};
      if (s_act_valid) begin
         if (pre == 0) begin
            e = 1; c = 2;
         end else begin
            h = mq[d].pop_front();
            ok = (a.kind == h.kind) && ((h.kind == 2'd0) || ((a.dest == h.dest) &&
                 (a.data == ((h.kind == 2'd1 && h.dest[4:0] == 5'd0) ? 32'd0 : h.data))));
            if (ok) begin
               if (m_match[d] < 64'hFFFF_FFFF) m_match[d]++;
            end else begin
               m_mis[d] = 1; e = 1; c = 1;
               if (m_miscnt[d] < 64'hFFFF) m_miscnt[d]++;
            end
         end
      end
`ifdef COMMIT_SB_TIMEOUT_EN
      if (!e && m_idle[d] == TMO) begin e = 1; c = 3; end
      if (s_act_valid) m_idle[d] = 0;
      else if (pre != 0 && m_idle[d] < TMO) m_idle[d]++;
`endif
      if (!e && s_eot && pre != 0) begin e = 1; c = 4; end
      fin = s_eot && pre == 0 && !s_act_valid;
      if (s_exp_valid && pre < DEPTH)
         mq[d].push_back('{kind: s_exp_kind, dest: s_exp_dest, data: s_exp_data});
      if (e) begin
         m_err[d] = 1;
         if (m_code[d] == 0) m_code[d] = c;
      end
      if (e && d == 0) m_state[d] = M_ERR;
      else if (fin)    m_state[d] = M_DONE;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else begin
         model_step(0);
         model_step(1);
      end
   end

   task automatic cmp_dut(input int d, input string t, input logic rdy, input logic [OW-1:0] occ,
                          input logic mis, input logic err, input logic [2:0] code, input logic hr,
                          input logic dn, input logic [31:0] mc, input logic [15:0] xc);
      chk({t, ".exp_ready"},    rdy,  (m_state[d] == M_RUN) && (mq[d].size() < DEPTH));
      chk({t, ".occupancy"},    occ,  mq[d].size());
      chk({t, ".mismatch"},     mis,  m_mis[d]);
      chk({t, ".err"},          err,  m_err[d]);
      chk({t, ".err_code"},     code, m_code[d]);
      chk({t, ".halt_req"},     hr,   m_state[d] == M_ERR);
      chk({t, ".done"},         dn,   m_state[d] == M_DONE);
      chk({t, ".match_cnt"},    mc,   m_match[d]);
      chk({t, ".mismatch_cnt"}, xc,   m_miscnt[d]);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_dut(0, "halt", if_h.exp_ready, if_h.occupancy, if_h.mismatch, if_h.err, if_h.err_code,
                 if_h.halt_req, if_h.done, if_h.match_cnt, if_h.mismatch_cnt);
         cmp_dut(1, "cont", if_c.exp_ready, if_c.occupancy, if_c.mismatch, if_c.err, if_c.err_code,
                 if_c.halt_req, if_c.done, if_c.match_cnt, if_c.mismatch_cnt);
      end
   end

   task automatic idle();
      s_exp_valid = 0; s_act_valid = 0; s_eot = 0;
   endtask
   task automatic push(input logic [1:0] k, input logic [31:0] dst, input logic [31:0] dat);
      s_exp_valid = 1; s_exp_kind = k; s_exp_dest = dst; s_exp_data = dat;
   endtask
   task automatic act(input logic [1:0] k, input logic [31:0] dst, input logic [31:0] dat);
      s_act_valid = 1; s_act_kind = k; s_act_dest = dst; s_act_data = dat;
   endtask
   task automatic tick();
      @(posedge clk); #1; idle();
   endtask
   task automatic ticks(input int n);
      repeat (n) tick();
   endtask
   task automatic probe();
      @(negedge clk);
   endtask
   task automatic reset_all();
      @(posedge clk); #1; rst = 0; idle();
      ticks(2);
      rst = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach its end");
      $fatal(1, "simulation time limit exceeded");
   end

   initial begin
      s_exp_kind = 0; s_exp_dest = 0; s_exp_data = 0;
      s_act_kind = 0; s_act_dest = 0; s_act_data = 0;
      idle();
      model_reset();
      #2 rst = 0;
      chk_en = 1;
      probe();
      chk("reset.exp_ready", if_h.exp_ready, 1);
      chk("reset.occupancy", if_c.occupancy, 0);
      chk("reset.err_code",  if_h.err_code, 0);
      chk("reset.match_cnt", if_c.match_cnt, 0);
      @(posedge clk); #1 rst = 1;

      // In-order matches: REG, REG x0 (act data must be 0), NONE (kind only)
      push(2'd1, 32'd5, 32'h0000_000A); tick();
      act(2'd1, 32'd5, 32'hA); tick();
      probe();
      chk("match.match_cnt", if_h.match_cnt, 1);
      chk("match.mismatch",  if_h.mismatch, 0);
      chk("match.occupancy", if_h.occupancy, 0);
      chk("match.model_cnt", m_match[0], 1);
      push(2'd1, 32'd0, 32'h1234); tick();
      act(2'd1, 32'd0, 32'h0); tick();
      push(2'd0, 32'd1, 32'd2); tick();
      act(2'd0, 32'd9, 32'd7); tick();
      probe();
      chk("match3.match_cnt", if_c.match_cnt, 3);
      chk("match3.err",       if_c.err, 0);

      // Data mismatch
      reset_all();
      push(2'd2, 32'h10, 32'h55); tick();
      act(2'd2, 32'h10, 32'h54); tick();
      probe();
      chk("data.mismatch",  if_h.mismatch, 1);
      chk("data.err_code",  if_h.err_code, 1);
      chk("data.halt_req",  if_h.halt_req, 1);
      chk("data.cont_halt", if_c.halt_req, 0);
      tick(); probe();
      chk("data.pulse_end", if_h.mismatch, 0);
      push(2'd1, 32'd0, 32'h5); tick();
      act(2'd1, 32'd0, 32'h5); tick();
      probe();
      chk("x0.mismatch_cnt", if_c.mismatch_cnt, 2);
      chk("x0.err_code_held", if_c.err_code, 1);
      chk("x0.model_miscnt", m_miscnt[1], 2);

      // Full queue, pop while full, refill, drain with pointer wrap
      reset_all();
      for (int i = 0; i < 8; i++) begin
         push(2'd1, 32'(i), 32'(3 * i)); tick();
      end
      probe();
      chk("full.exp_ready_h", if_h.exp_ready, 0);
      chk("full.exp_ready_c", if_c.exp_ready, 0);
      chk("full.occupancy",   if_c.occupancy, 8);
      push(2'd1, 32'd8, 32'd24); act(2'd1, 32'd0, 32'd0); tick();
      probe();
      chk("full.pop_occ",   if_c.occupancy, 7);
      chk("full.pop_ready", if_c.exp_ready, 1);
      push(2'd1, 32'd8, 32'd24); tick();
      probe();
      chk("full.ninth_occ", if_c.occupancy, 8);
      for (int i = 1; i <= 8; i++) begin
         act(2'd1, 32'(i), 32'(3 * i)); tick();
      end
      probe();
      chk("drain.match_cnt", if_c.match_cnt, 9);
      push(2'd2, 32'h100, 32'hAB); tick();
      push(2'd2, 32'h104, 32'hCD); act(2'd2, 32'h100, 32'hAB); tick();
      probe();
      chk("simul.occupancy", if_c.occupancy, 1);
      act(2'd2, 32'h104, 32'hCD); tick();
      probe();
      chk("simul.drained",   if_c.occupancy, 0);
      chk("simul.match_cnt", if_c.match_cnt, 11);

      // Unexpected commit with a same-cycle push
      reset_all();
      act(2'd1, 32'd1, 32'h1); push(2'd1, 32'd2, 32'h20); tick();
      probe();
      chk("unexp.err_code_h", if_h.err_code, 2);
      chk("unexp.err_code_c", if_c.err_code, 2);
      chk("unexp.occupancy",  if_c.occupancy, 1);
      act(2'd1, 32'd2, 32'h20); tick();
      probe();
      chk("unexp.cont_match", if_c.match_cnt, 1);
      chk("unexp.halt_match", if_h.match_cnt, 0);

      // Watchdog
      reset_all();
      push(2'd1, 32'd3, 32'h33); tick();
      ticks(3); probe();
      chk("wdog.early_err", if_h.err, 0);
      ticks(3); probe();
`ifdef COMMIT_SB_TIMEOUT_EN
      chk("wdog.err_code_h", if_h.err_code, 3);
      chk("wdog.err_code_c", if_c.err_code, 3);
`else
      chk("wdog.no_err_h", if_h.err, 0);
      chk("wdog.no_err_c", if_c.err, 0);
`endif

      // End of test: leftovers, clean finish, mid-test reset
      reset_all();
      push(2'd1, 32'd1, 32'd1); tick();
      push(2'd1, 32'd2, 32'd2); tick();
      s_eot = 1; tick();
      probe();
      chk("eot.leftover_h", if_h.err_code, 4);
      chk("eot.leftover_c", if_c.err_code, 4);
      reset_all();
      s_eot = 1; tick();
      probe();
      chk("eot.done_h",  if_h.done, 1);
      chk("eot.done_c",  if_c.done, 1);
      chk("eot.ready_h", if_h.exp_ready, 0);
      reset_all();
      for (int i = 0; i < 3; i++) begin
         push(2'd2, 32'(16 * i), 32'(i + 1)); tick();
      end
      probe();
      chk("rst.pre_occ", if_c.occupancy, 3);
      @(posedge clk); #3 rst = 0;
      #1;
      chk("rst.occ_h", if_h.occupancy, 0);
      chk("rst.occ_c", if_c.occupancy, 0);
      @(posedge clk); #1 rst = 1;
      push(2'd1, 32'd7, 32'h70); tick();
      act(2'd1, 32'd7, 32'h70); tick();
      probe();
      chk("rst.match_h", if_h.match_cnt, 1);
      chk("rst.halt_h",  if_h.halt_req, 0);
      chk("rst.err_c",   if_c.err, 0);
      ticks(2); probe();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
